// File: rtl/risc_pkg.sv
// Shared definitions for the branch/PC datapath: branch opcodes, flag bit
// positions, sequencer states and word width.
package risc_pkg;

  localparam int WORD_W = 32;

  localparam logic [3:0] BR_NONE = 4'b0000;
  localparam logic [3:0] BR_B    = 4'b0001;
  localparam logic [3:0] BR_BL   = 4'b0010;
  localparam logic [3:0] BR_BR   = 4'b0011;
  localparam logic [3:0] BR_BLTZ = 4'b0100;
  localparam logic [3:0] BR_BZ   = 4'b0101;
  localparam logic [3:0] BR_BNZ  = 4'b0110;
  localparam logic [3:0] BR_BCY  = 4'b0111;
  localparam logic [3:0] BR_BNCY = 4'b1000;
  localparam logic [3:0] BR_HALT = 4'b1001;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution: decides whether the current branch op
// redirects the PC and whether it writes the link register.
module branch_cond
  import risc_pkg::*;
(
  input  logic [3:0]        br_op,
  input  logic [FLAG_NEG:0] flags,   // zero/negative flags of the current instruction
  input  logic              carry_q,
  output logic              take,
  output logic              is_link
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    take    = 1'b0;
    is_link = 1'b0;
    case (br_op)
      BR_B:    take = 1'b1;
      BR_BL: begin
        take    = 1'b1;
        is_link = 1'b1;
      end
      BR_BR:   take = 1'b1;
      BR_BLTZ: take = flags[FLAG_NEG];
      BR_BZ:   take = flags[FLAG_ZERO];
      BR_BNZ:  take = !flags[FLAG_ZERO];
      BR_BCY:  take = carry_q;
      BR_BNCY: take = !carry_q;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner: sequences fetch addresses, resolves branches,
// generates flush/link pulses and keeps the carry latch for bcy/bncy.
module pc_branch_unit
  import risc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WORD_W-1:0] PC_STEP      = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        br_op,
  input  logic [2:0]        flags,
  input  logic              carry_we,
  input  logic [WORD_W-1:0] rs_val,
  input  logic [WORD_W-1:0] target,
  output logic [WORD_W-1:0] pc,
  output logic              taken,
  output logic              link_we,
  output logic [WORD_W-1:0] link_data,
  output logic              halted
);

  logic [1:0]        state;
  logic              carry_q;
  logic              take;
  logic              is_link;
  logic [WORD_W-1:0] seq_pc;
  logic [WORD_W-1:0] next_pc;

  branch_cond u_branch_cond (
    .br_op   (br_op),
    .flags   (flags[FLAG_NEG:0]),
    .carry_q (carry_q),
    .take    (take),
    .is_link (is_link)
  );

  // Sequential increment wraps modulo 2^32 by construction.
  assign seq_pc  = pc + PC_STEP;
  assign next_pc = !take           ? seq_pc :
                   (br_op == BR_BR) ? word_align(rs_val) : word_align(target);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_VECTOR;
      carry_q   <= 1'b0;
      taken     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
      halted    <= 1'b0;
      state     <= S_INIT;
    end else if (!en) begin
      // Stall: hold state but drop pulses so they never repeat.
      taken   <= 1'b0;
      link_we <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
      taken   <= 1'b0;
      link_we <= 1'b0;
      case (state)
        S_INIT: state <= S_RUN;
        S_RUN: begin
          if (carry_we) carry_q <= flags[FLAG_CARRY];
          if (br_op == BR_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            pc      <= next_pc;
            taken   <= take;
            link_we <= is_link;
            if (is_link) link_data <= seq_pc;
          end
        end
        default: halted <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: each step pushes its expected outputs to
// a scoreboard queue, which is popped and compared after the clock edge.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  br_op;
  logic [2:0]  flags;
  logic        carry_we;
  logic [31:0] rs_val;
  logic [31:0] target;
  logic [31:0] pc;
  logic        taken;
  logic        link_we;
  logic [31:0] link_data;
  logic        halted;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        taken;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .br_op     (br_op),
    .flags     (flags),
    .carry_we  (carry_we),
    .rs_val    (rs_val),
    .target    (target),
    .pc        (pc),
    .taken     (taken),
    .link_we   (link_we),
    .link_data (link_data),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] e_pc, input logic e_taken,
                      input logic e_lwe, input logic [31:0] e_ld, input logic e_halt);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.taken = e_taken;
    e.link_we = e_lwe; e.link_data = e_ld; e.halted = e_halt;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".pc"},        pc,                e.pc);
    check({e.tag, ".taken"},     {31'd0, taken},    {31'd0, e.taken});
    check({e.tag, ".link_we"},   {31'd0, link_we},  {31'd0, e.link_we});
    check({e.tag, ".link_data"}, link_data,         e.link_data);
    check({e.tag, ".halted"},    {31'd0, halted},   {31'd0, e.halted});
  endtask

  // Drive one instruction, push its expected outcome, clock it, compare.
  task automatic step(input string tag, input logic s_en, input logic [3:0] op,
                      input logic [2:0] fl, input logic cwe, input logic [31:0] rs,
                      input logic [31:0] tgt, input logic [31:0] e_pc, input logic e_taken,
                      input logic e_lwe, input logic [31:0] e_ld, input logic e_halt);
    en = s_en; br_op = op; flags = fl; carry_we = cwe; rs_val = rs; target = tgt;
    push(tag, e_pc, e_taken, e_lwe, e_ld, e_halt);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; br_op = 4'd0; flags = 3'd0; carry_we = 1'b0;
    rs_val = '0; target = '0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    pop_compare();
    @(negedge clk);
    rst = 1'b1;

    // Init cycle then sequential fetch.
    step("init",  1, 4'b0000, 3'b000, 0, 0, 0, 32'h00, 0, 0, 32'h0, 0);
    step("seq1",  1, 4'b0000, 3'b000, 0, 0, 0, 32'h04, 0, 0, 32'h0, 0);
    step("seq2",  1, 4'b0000, 3'b000, 0, 0, 0, 32'h08, 0, 0, 32'h0, 0);
    step("seq3",  1, 4'b0000, 3'b000, 0, 0, 0, 32'h0C, 0, 0, 32'h0, 0);
    step("seq4",  1, 4'b0000, 3'b000, 0, 0, 0, 32'h10, 0, 0, 32'h0, 0);

    // BZ taken / one-cycle pulse / BZ not taken.
    step("bz_t",   1, 4'b0101, 3'b001, 0, 0, 32'h40, 32'h40, 1, 0, 32'h0, 0);
    step("bz_pls", 1, 4'b0000, 3'b000, 0, 0, 0,      32'h44, 0, 0, 32'h0, 0);
    step("br_10",  1, 4'b0011, 3'b000, 0, 32'h10, 0, 32'h10, 1, 0, 32'h0, 0);
    step("bz_nt",  1, 4'b0101, 3'b000, 0, 0, 32'h40, 32'h14, 0, 0, 32'h0, 0);

    // Carry latch: set then BCY taken; clear, then same-cycle carry_we+BCY uses old value.
    step("add_c1", 1, 4'b0000, 3'b100, 1, 0, 0,       32'h18, 0, 0, 32'h0, 0);
    step("bcy_t",  1, 4'b0111, 3'b000, 0, 0, 32'h80,  32'h80, 1, 0, 32'h0, 0);
    step("add_c0", 1, 4'b0000, 3'b000, 1, 0, 0,       32'h84, 0, 0, 32'h0, 0);
    step("bcy_old",1, 4'b0111, 3'b100, 1, 0, 32'h200, 32'h88, 0, 0, 32'h0, 0);
    step("bncy_nt",1, 4'b1000, 3'b000, 0, 0, 32'h300, 32'h8C, 0, 0, 32'h0, 0);

    // BLTZ with unaligned target, BL link, BR low bits cleared.
    step("bltz",   1, 4'b0100, 3'b010, 0, 0, 32'h23,  32'h20,  1, 0, 32'h0,  0);
    step("bl",     1, 4'b0010, 3'b000, 0, 0, 32'h100, 32'h100, 1, 1, 32'h24, 0);
    step("br_26",  1, 4'b0011, 3'b000, 0, 32'h26, 0,  32'h24,  1, 0, 32'h24, 0);
    step("bnz",    1, 4'b0110, 3'b000, 0, 0, 32'h2C,  32'h2C,  1, 0, 32'h24, 0);
    step("b_pc4",  1, 4'b0001, 3'b001, 0, 0, 32'h30,  32'h30,  1, 0, 32'h24, 0);

    // Stall with a pending taken BZ, then release.
    step("stall0", 0, 4'b0101, 3'b001, 0, 0, 32'h40, 32'h30, 0, 0, 32'h24, 0);
    step("stall1", 0, 4'b0101, 3'b001, 0, 0, 32'h40, 32'h30, 0, 0, 32'h24, 0);
    step("stall2", 0, 4'b0101, 3'b001, 0, 0, 32'h40, 32'h30, 0, 0, 32'h24, 0);
    step("release",1, 4'b0101, 3'b001, 0, 0, 32'h40, 32'h40, 1, 0, 32'h24, 0);
    step("after",  1, 4'b0000, 3'b000, 0, 0, 0,      32'h44, 0, 0, 32'h24, 0);
    step("op_rsvd",1, 4'b1100, 3'b111, 0, 0, 32'h80, 32'h48, 0, 0, 32'h24, 0);

    // Wrap-around of the sequential increment.
    step("br_top", 1, 4'b0011, 3'b000, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 1, 0, 32'h24, 0);
    step("wrap",   1, 4'b0000, 3'b000, 0, 0, 0,             32'h0,         0, 0, 32'h24, 0);

    // HALT at 0x30, then random traffic must be ignored.
    step("br_30",  1, 4'b0011, 3'b000, 0, 32'h30, 0, 32'h30, 1, 0, 32'h24, 0);
    step("halt",   1, 4'b1001, 3'b000, 0, 0, 0,      32'h30, 0, 0, 32'h24, 1);
    for (int i = 0; i < 5; i++) begin
      step("halt_hold", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           32'h30, 0, 0, 32'h24, 1);
    end

    // Asynchronous reset mid-cycle clears everything at once.
    #2;
    rst = 1'b0;
    #1;
    push("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    pop_compare();
    @(negedge clk);
    rst = 1'b1;
    step("re_init", 1, 4'b0001, 3'b000, 0, 0, 32'h80, 32'h00, 0, 0, 32'h0, 0);
    step("re_seq",  1, 4'b0000, 3'b000, 0, 0, 0,      32'h04, 0, 0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
